// File: rtl/fetch_unit.sv
// Instruction fetch front end: one-cycle memory fetch, DEPTH-entry prefetch queue and
// valid/ready issue port that delivers an Ldl opcode together with its literal word.
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] i_addr,
    input  logic [15:0] i_bus,
    input  logic        redirect,
    input  logic [15:0] redirect_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_lit,
    output logic        out_has_lit,
    output logic [15:0] out_pc
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW:0] DEPTH_A = (AW+1)'(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    function automatic logic is_ldl(input logic [15:0] w);
        return (w[15:8] == 8'hFF) && (w[7:4] == 4'h1);
    endfunction

    // Circular-pointer advance by 0..2; one subtraction suffices since p+n < 2*DEPTH.
    function automatic logic [AW-1:0] ptr_add(input logic [AW-1:0] p, input logic [1:0] n);
        logic [AW:0] s;
        s = {1'b0, p} + (AW+1)'(n);
        if (s >= DEPTH_A) s = s - DEPTH_A;
        return s[AW-1:0];
    endfunction

    logic [15:0]   pc_q, pc_d;
    logic          inflight_q, inflight_d;
    logic [15:0]   inflight_pc_q, inflight_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [15:0]   word_q [DEPTH];
    logic [15:0]   wpc_q  [DEPTH];

    logic [15:0]   head_word;
    logic [15:0]   head_pc;
    logic [15:0]   lit_word;
    logic          head_ldl;
    logic          valid;
    logic [1:0]    pop_n;
    logic [CW-1:0] cnt_after_pop;
    logic [CW:0]   occ;
    logic          fetch_en;

    assign head_word = word_q[rd_q];
    assign head_pc   = wpc_q[rd_q];
    assign lit_word  = word_q[ptr_add(rd_q, 2'd1)];
    assign head_ldl  = is_ldl(head_word);

    // An Ldl head is only issuable once its literal sits behind it.
    assign valid = ((count_q != '0) && !head_ldl) || (count_q >= CW'(2));
    assign pop_n = (valid && out_ready) ? (head_ldl ? 2'd2 : 2'd1) : 2'd0;

    // Occupancy after this edge's pop and capture; the word requested now lands next edge.
    assign cnt_after_pop = count_q - CW'(pop_n);
    assign occ           = {1'b0, cnt_after_pop} + (CW+1)'(inflight_q);
    assign fetch_en      = occ < DEPTH_C;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        rd_d          = rd_q;
        wr_d          = wr_q;
        if (redirect) begin
            pc_d       = redirect_addr;
            inflight_d = 1'b0;
            count_d    = '0;
            rd_d       = '0;
            wr_d       = '0;
        end else begin
            rd_d    = ptr_add(rd_q, pop_n);
            wr_d    = inflight_q ? ptr_add(wr_q, 2'd1) : wr_q;
            count_d = occ[CW-1:0];
            if (fetch_en) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + 16'd1;
            end else begin
                inflight_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            rd_q          <= '0;
            wr_q          <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
        end
    end

    // Queue storage carries no reset; outputs are masked by valid instead.
    always_ff @(posedge clk) begin
        if (inflight_q && !redirect) begin
            word_q[wr_q] <= i_bus;
            wpc_q[wr_q]  <= inflight_pc_q;
        end
    end

    assign i_addr      = pc_q;
    assign out_valid   = valid;
    assign out_instr   = valid ? head_word : '0;
    assign out_pc      = valid ? head_pc : '0;
    assign out_has_lit = valid && head_ldl;
    assign out_lit     = (valid && head_ldl) ? lit_word : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected issues are queued from a memory walk when stimulus
// is applied and compared as the decoder handshake completes.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] lit;
        logic        has;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] i_addr, i_bus;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        out_valid, out_ready, out_has_lit;
    logic [15:0] out_instr, out_lit, out_pc;

    logic [15:0] i_addr2, i_bus2;
    logic        redirect2, out_ready2;
    logic [15:0] redirect_addr2;
    logic        out_valid2, out_has_lit2;
    logic [15:0] out_instr2, out_lit2, out_pc2;

    logic [15:0] mem [65536];
    exp_t        exp_q [$];
    int          total, bad;

    logic        pv, prdy, predir, prst, phas;
    logic [15:0] pinstr, plit, ppc;

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .i_addr(i_addr), .i_bus(i_bus),
        .redirect(redirect), .redirect_addr(redirect_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_lit(out_lit), .out_has_lit(out_has_lit), .out_pc(out_pc)
    );

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_addr(i_addr2), .i_bus(i_bus2),
        .redirect(redirect2), .redirect_addr(redirect_addr2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
        .out_lit(out_lit2), .out_has_lit(out_has_lit2), .out_pc(out_pc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle synchronous memories.
    always @(posedge clk) i_bus <= mem[i_addr];
    always @(posedge clk)
        i_bus2 <= (i_addr2 == 16'hFFFF) ? 16'hFF11 : (i_addr2 == 16'h0000) ? 16'h0001 : 16'h1000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic ldl(input logic [15:0] w);
        return (w[15:8] == 8'hFF) && (w[7:4] == 4'h1);
    endfunction

    task automatic push_stream(input logic [15:0] start, input int n);
        logic [15:0] p, q;
        exp_t e;
        p = start;
        for (int k = 0; k < n; k++) begin
            q       = p + 16'd1;
            e.pc    = p;
            e.instr = mem[p];
            if (ldl(mem[p])) begin
                e.lit = mem[q];
                e.has = 1'b1;
                p     = p + 16'd2;
            end else begin
                e.lit = 16'h0000;
                e.has = 1'b0;
                p     = q;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_iaddr", 32'(i_addr), 0);
        chk("rst_iaddr2", 32'(i_addr2), 32'hFFFF);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag, input int max);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        chk(tag, 32'(exp_q.size()), 0);
    endtask

    task automatic monitor_step();
        exp_t e;
        if (!out_valid) begin
            chk("zero_instr_lit", {out_instr, out_lit}, 0);
            chk("zero_pc_has", {15'd0, out_has_lit, out_pc}, 0);
        end
        if (pv && !prdy && !predir && prst && rst_n) begin
            chk("stall_instr", 32'(out_instr), 32'(pinstr));
            chk("stall_lit", 32'(out_lit), 32'(plit));
            chk("stall_pc", 32'(out_pc), 32'(ppc));
            chk("stall_has", 32'(out_has_lit), 32'(phas));
        end
        if (rst_n && out_valid && out_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", 32'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                chk("iss_pc", 32'(out_pc), 32'(e.pc));
                chk("iss_instr", 32'(out_instr), 32'(e.instr));
                chk("iss_lit", 32'(out_lit), 32'(e.lit));
                chk("iss_has", 32'(out_has_lit), 32'(e.has));
            end
        end
        if (32'(dut.count_q) > DEPTH) chk("queue_overflow", 32'(dut.count_q), DEPTH);
        pv = out_valid; prdy = out_ready; predir = redirect; prst = rst_n;
        pinstr = out_instr; plit = out_lit; ppc = out_pc; phas = out_has_lit;
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; redirect = 1'b0; redirect_addr = 16'h0000; out_ready = 1'b0;
        redirect2 = 1'b0; redirect_addr2 = 16'h0000; out_ready2 = 1'b1;
        pv = 1'b0; prdy = 1'b0; predir = 1'b0; prst = 1'b0; phas = 1'b0;
        pinstr = '0; plit = '0; ppc = '0;
        for (int i = 0; i < 65536; i++) mem[i] = {4'h1, 12'(i)};

        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
            begin
                #200000;
                $display("FAIL timeout: bench did not complete");
                $fatal(1, "timeout");
            end
        join_none

        // Ldl pair at reset PC, plus the wrapping RESET_PC=FFFF instance.
        mem[0] = 16'hFF10; mem[1] = 16'h0000; mem[2] = 16'h1010;
        out_ready = 1'b1;
        reset_dut();
        push_stream(16'h0000, 5);
        @(negedge clk);
        chk("t1_valid_e1", 32'(out_valid), 0);
        chk("t4_iaddr_e1", 32'(i_addr2), 32'h0000);
        @(negedge clk);
        chk("t1_valid_e2", 32'(out_valid), 0);
        chk("t4_iaddr_e2", 32'(i_addr2), 32'h0001);
        chk("t4_valid_e2", 32'(out_valid2), 0);
        @(negedge clk);
        chk("t1_valid_e3", 32'(out_valid), 1);
        chk("t4_valid_e3", 32'(out_valid2), 1);
        chk("t4_pc", 32'(out_pc2), 32'hFFFF);
        chk("t4_instr", 32'(out_instr2), 32'hFF11);
        chk("t4_lit", 32'(out_lit2), 32'h0001);
        chk("t4_has", 32'(out_has_lit2), 1);
        drain("t1_drain", 30);

        // Ready held low from reset: queue fills, fetch address freezes.
        mem[0] = 16'h1000; mem[1] = 16'h1001; mem[2] = 16'h1002;
        reset_dut();
        repeat (10) tick();
        chk("t2_iaddr", 32'(i_addr), DEPTH);
        chk("t2_count", 32'(dut.count_q), DEPTH);
        chk("t2_head_pc", 32'(out_pc), 0);
        push_stream(16'h0000, 4);
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t2_no_gap", 32'(out_valid), 1);
            tick();
        end
        out_ready = 1'b0;
        chk("t2_sb", 32'(exp_q.size()), 0);

        // Redirect while the queue holds pcs 3..5.
        mem[6] = 16'h1010;
        reset_dut();
        repeat (6) tick();
        push_stream(16'h0000, 3);
        out_ready = 1'b1;
        repeat (3) tick();
        chk("t3_count", 32'(dut.count_q), 3);
        chk("t3_head", 32'(out_pc), 3);
        out_ready = 1'b0; redirect = 1'b1; redirect_addr = 16'h0006;
        chk("t3_sb", 32'(exp_q.size()), 0);
        push_stream(16'h0006, 3);
        tick();
        redirect = 1'b0; out_ready = 1'b1;
        chk("t3_flushed", 32'(dut.count_q), 0);
        @(negedge clk); chk("t3_gap1", 32'(out_valid), 0);
        @(negedge clk); chk("t3_gap2", 32'(out_valid), 0);
        @(negedge clk); chk("t3_valid", 32'(out_valid), 1);
        chk("t3_pc", 32'(out_pc), 6);
        drain("t3_drain", 30);

        // Redirect coinciding with an accepted issue.
        repeat (3) tick();
        chk("t5a_valid", 32'(out_valid), 1);
        exp_q.delete();
        push_stream(16'h0020, 3);
        out_ready = 1'b1; redirect = 1'b1; redirect_addr = 16'h0020;
        tick();
        redirect = 1'b0;
        chk("t5a_flushed", 32'(dut.count_q), 0);
        drain("t5a_drain", 30);

        // Redirect on the edge that captures an Ldl literal; target is itself an Ldl.
        mem[16'h40] = 16'hFF12; mem[16'h41] = 16'hABCD;
        mem[16'h50] = 16'hFF13; mem[16'h51] = 16'h1234;
        redirect = 1'b1; redirect_addr = 16'h0040;
        tick();
        redirect = 1'b0;
        repeat (2) tick();
        chk("t5b_split", 32'(dut.count_q), 1);
        chk("t5b_split_v", 32'(out_valid), 0);
        push_stream(16'h0050, 3);
        redirect = 1'b1; redirect_addr = 16'h0050; out_ready = 1'b1;
        tick();
        redirect = 1'b0;
        chk("t5b_flushed", 32'(dut.count_q), 0);
        @(negedge clk); chk("t5b_gap1", 32'(out_valid), 0);
        @(negedge clk); chk("t5b_gap2", 32'(out_valid), 0);
        @(negedge clk); chk("t5b_gap3", 32'(out_valid), 0);
        @(negedge clk); chk("t5b_valid", 32'(out_valid), 1);
        drain("t5b_drain", 30);

        // Asynchronous reset pulse mid-stream, then the Ldl restart sequence again.
        repeat (6) tick();
        chk("t6_pre_valid", 32'(out_valid), 1);
        mem[0] = 16'hFF10; mem[1] = 16'h0000; mem[2] = 16'h1010;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_instr", 32'(out_instr), 0);
        chk("t6_pc", 32'(out_pc), 0);
        chk("t6_iaddr", 32'(i_addr), 0);
        chk("t6_iaddr2", 32'(i_addr2), 32'hFFFF);
        exp_q.delete();
        push_stream(16'h0000, 2);
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); chk("t6_valid_e1", 32'(out_valid), 0);
        @(negedge clk); chk("t6_valid_e2", 32'(out_valid), 0);
        @(negedge clk); chk("t6_valid_e3", 32'(out_valid), 1);
        drain("t6_drain", 30);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
